// File: rtl/sd_photo_pkg.sv
// Shared constants, FSM state encoding and BMP header field values for the SD photo writer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sd_photo_pkg;

    // Default geometry: 512-byte SD sectors, 54-byte BMP header, both counted in 16-bit words.
    localparam int SEC_WORDS_DFLT = 256;
    localparam int HDR_WORDS_DFLT = 27;

    // BMP header field values.
    localparam logic [15:0] BMP_MAGIC      = 16'h4D42;  // "BM", little-endian
    localparam logic [31:0] BMP_HDR_BYTES  = 32'd54;    // file header + info header
    localparam logic [15:0] BMP_INFO_BYTES = 16'd40;    // BITMAPINFOHEADER size
    localparam logic [15:0] BMP_PPM        = 16'd2835;  // 72 dpi in pixels per metre
    localparam logic [15:0] BMP_PLANES     = 16'd1;
    localparam logic [15:0] BMP_BPP        = 16'd16;    // RGB565

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEC_START,
        ST_WAIT_BUSY_H,
        ST_XFER,
        ST_WAIT_BUSY_L,
        ST_NEXT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/bmp_hdr_gen.sv
// Maps a header word index plus image width/height to the 16-bit BMP header word.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the word is used.
module bmp_hdr_gen
    import sd_photo_pkg::*;
(
    input  logic [7:0]  idx_i,
    input  logic [10:0] img_w_i,
    input  logic [10:0] img_h_i,
    output logic [15:0] word_o
);

    logic [21:0] pix_cnt;
    logic [31:0] img_bytes;
    logic [31:0] file_bytes;

    // Select the header field for this word; unlisted words are reserved/zero fields.
    always_comb begin
        pix_cnt    = 22'(img_w_i) * 22'(img_h_i);
        img_bytes  = {9'd0, pix_cnt, 1'b0};
        file_bytes = img_bytes + BMP_HDR_BYTES;
        word_o     = 16'h0000;
        case (idx_i)
            8'd0:  word_o = BMP_MAGIC;
            8'd1:  word_o = file_bytes[15:0];
            8'd2:  word_o = file_bytes[31:16];
            8'd5:  word_o = BMP_HDR_BYTES[15:0];
            8'd7:  word_o = BMP_INFO_BYTES;
            8'd9:  word_o = {5'd0, img_w_i};
            8'd11: word_o = {5'd0, img_h_i};
            8'd13: word_o = BMP_PLANES;
            8'd14: word_o = BMP_BPP;
            8'd17: word_o = img_bytes[15:0];
            8'd18: word_o = img_bytes[31:16];
            8'd19: word_o = BMP_PPM;
            8'd21: word_o = BMP_PPM;
            default: word_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/sd_write_photo.sv
// Streams a BMP image (header, RGB565 pixels, zero padding) to an SD controller sector by sector.
// Latency: wr_data updates exactly 2 cycles after an accepted wr_req; src_rd_en is combinational from wr_req.
// Backpressure: paced entirely by wr_req/wr_busy from the SD controller; no stall on the pixel source.
module sd_write_photo
    import sd_photo_pkg::*;
#(
    parameter int SEC_WORDS = SEC_WORDS_DFLT,
    parameter int HDR_WORDS = HDR_WORDS_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] sec_start_addr,
    input  logic [10:0] img_w,
    input  logic [10:0] img_h,
    output logic        src_rd_en,
    input  logic [15:0] src_data,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(SEC_WORDS + 1);

    state_e         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [CW-1:0]  wcnt_q, wcnt_d;      // words served in the current sector
    logic [23:0]    g_q, g_d;            // global word index within the image
    logic [23:0]    tot_q, tot_d;        // header + pixel words
    logic [10:0]    w_q, w_d;
    logic [10:0]    h_q, h_d;

    logic           s1_vld_q;
    logic           s1_pix_q;
    logic [15:0]    s1_word_q;
    logic [15:0]    wr_data_q;

    logic           accept;
    logic           is_hdr;
    logic           is_pix;
    logic [15:0]    hdr_word;
    logic [21:0]    pix_prod;

    bmp_hdr_gen u_hdr (
        .idx_i   (g_q[7:0]),
        .img_w_i (w_q),
        .img_h_i (h_q),
        .word_o  (hdr_word)
    );

    // Classify the current word and decide whether this wr_req is served.
    always_comb begin
        pix_prod = 22'(img_w) * 22'(img_h);
        is_hdr   = (g_q < 24'(HDR_WORDS));
        is_pix   = !is_hdr && (g_q < tot_q);
        accept   = (state_q == ST_XFER) && wr_req && (wcnt_q < CW'(SEC_WORDS));
    end

    assign src_rd_en   = accept && is_pix;
    assign wr_start_en = (state_q == ST_SEC_START);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign wr_sec_addr = addr_q;
    assign wr_data     = wr_data_q;

    // Next-state and counter updates for the sector sequencing FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        g_d     = g_q;
        tot_d   = tot_q;
        w_d     = w_q;
        h_d     = h_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEC_START;
                    addr_d  = sec_start_addr;
                    w_d     = img_w;
                    h_d     = img_h;
                    tot_d   = 24'(HDR_WORDS) + {2'b00, pix_prod};
                    g_d     = 24'd0;
                end
            end
            ST_SEC_START: begin
                wcnt_d  = '0;
                state_d = ST_WAIT_BUSY_H;
            end
            ST_WAIT_BUSY_H: begin
                if (wr_busy) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (accept) begin
                    wcnt_d = wcnt_q + CW'(1);
                    g_d    = g_q + 24'd1;
                    if (wcnt_q == CW'(SEC_WORDS - 1)) state_d = ST_WAIT_BUSY_L;
                end
            end
            ST_WAIT_BUSY_L: begin
                if (!wr_busy) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                // g sits on a sector boundary here; once it covers every meaningful word we are done.
                if (g_q >= tot_q) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + 32'd1;
                    state_d = ST_SEC_START;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            g_q     <= '0;
            tot_q   <= '0;
            w_q     <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            g_q     <= g_d;
            tot_q   <= tot_d;
            w_q     <= w_d;
            h_q     <= h_d;
        end
    end

    // Two-stage data path: stage 1 waits for the FIFO word, stage 2 presents the selected word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_pix_q  <= 1'b0;
            s1_word_q <= '0;
            wr_data_q <= '0;
        end else begin
            s1_vld_q  <= accept;
            s1_pix_q  <= is_pix;
            s1_word_q <= is_hdr ? hdr_word : 16'h0000;
            if (s1_vld_q) wr_data_q <= s1_pix_q ? src_data : s1_word_q;
        end
    end

endmodule
